// File: rtl/keypad_entry.sv
// Debounces the 3x4 keypad held-key vector, rejects ghost/multi-key patterns, and emits one event per press.
// It also builds a BCD entry buffer: '*' clears it and '#' commits it with a one-cycle entry_valid pulse.
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DIGITS          = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [11:0]                    key,
    output logic                           key_strobe,
    output logic [3:0]                     key_code,
    output logic [4*DIGITS-1:0]            entry_bcd,
    output logic [$clog2(DIGITS+1)-1:0]    digit_count,
    output logic [4*DIGITS-1:0]            entry_value,
    output logic [$clog2(DIGITS+1)-1:0]    entry_len,
    output logic                           entry_valid,
    output logic                           overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int NW = $clog2(DIGITS+1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES-1);
    localparam logic [NW-1:0] NUM_MAX  = NW'(DIGITS);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t        state, state_n;
    logic [11:0]   key_q;
    logic [11:0]   cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          accept;
    logic          one_hot;
    logic [3:0]    code;

    // Scanner bit order is 1..9, '*', 0, '#'; codes are 0-9, 10='*', 11='#'.
    function automatic logic [3:0] encode(input logic [11:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (v[i]) begin
                if (i < 9)        c = 4'(i + 1);
                else if (i == 9)  c = 4'd10;
                else if (i == 10) c = 4'd0;
                else              c = 4'd11;
            end
        end
        return c;
    endfunction

    assign one_hot = (key_q != 12'd0) && ((key_q & (key_q - 12'd1)) == 12'd0);
    assign code    = encode(cand);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            key_q <= 12'd0;
            cand  <= 12'd0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            key_q <= key;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    state_n = DEB_PRESS;
                    cand_n  = key_q;
                    cnt_n   = CW'(1);
                end
            end
            DEB_PRESS: begin
                if (key_q != cand) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    accept  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HELD: begin
                // Rolling onto another key while held never creates a second event.
                if (key_q == 12'd0) begin
                    state_n = DEB_REL;
                    cnt_n   = CW'(1);
                end
            end
            DEB_REL: begin
                if (key_q != 12'd0) begin
                    state_n = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_strobe  <= 1'b0;
            key_code    <= 4'd0;
            entry_bcd   <= '0;
            digit_count <= '0;
            entry_value <= '0;
            entry_len   <= '0;
            entry_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            key_strobe  <= accept;
            entry_valid <= 1'b0;
            overflow    <= 1'b0;
            if (accept) begin
                key_code <= code;
                if (code <= 4'd9) begin
                    if (digit_count < NUM_MAX) begin
                        entry_bcd   <= {entry_bcd[4*DIGITS-5:0], code};
                        digit_count <= digit_count + NW'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (code == 4'd10) begin
                    entry_bcd   <= '0;
                    digit_count <= '0;
                end else if (digit_count != '0) begin
                    entry_value <= entry_bcd;
                    entry_len   <= digit_count;
                    entry_valid <= 1'b1;
                    entry_bcd   <= '0;
                    digit_count <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed keypad scenarios plus random key traffic, all checked every cycle
// against a run-length/queue model of the press rules.
module tb_keypad_entry;

    localparam int DC = 4;
    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] key = 12'd0;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic [15:0] entry_bcd;
    logic [2:0]  digit_count;
    logic [15:0] entry_value;
    logic [2:0]  entry_len;
    logic        entry_valid;
    logic        overflow;

    keypad_entry #(.DEBOUNCE_CYCLES(DC), .DIGITS(ND)) dut (
        .clk(clk), .reset(reset), .key(key),
        .key_strobe(key_strobe), .key_code(key_code),
        .entry_bcd(entry_bcd), .digit_count(digit_count),
        .entry_value(entry_value), .entry_len(entry_len),
        .entry_valid(entry_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int n_strobe = 0, n_valid = 0, n_ovf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: a press fires when armed and DC identical one-hot samples have been seen;
    // re-arming needs DC consecutive all-zero samples. Digits live in a queue.
    int          code_of[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    int          q[$];
    int          zrun, orun;
    bit          armed;
    logic [11:0] mkq, mprev, s;
    logic        m_strobe, m_valid, m_ovf;
    logic [3:0]  m_code;
    logic [15:0] m_bcd, m_val;
    int          m_cnt, m_len;

    function automatic logic [15:0] pack_q();
        logic [15:0] r;
        r = 16'd0;
        foreach (q[i]) r = {r[11:0], 4'(q[i])};
        return r;
    endfunction

    task automatic model_press(input logic [11:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 12; i++) if (v[i]) c = code_of[i];
        m_strobe = 1'b1;
        m_code   = 4'(c);
        if (c <= 9) begin
            if (q.size() < ND) q.push_back(c);
            else m_ovf = 1'b1;
        end else if (c == 10) begin
            q.delete();
        end else if (q.size() > 0) begin
            m_val   = pack_q();
            m_len   = q.size();
            m_valid = 1'b1;
            q.delete();
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            zrun = 0; orun = 0; armed = 1'b1;
            mkq = 12'd0; mprev = 12'd0;
            m_strobe = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
            m_code = 4'd0; m_val = 16'd0; m_len = 0;
        end else begin
            s = mkq;
            m_strobe = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
            zrun = (s == 12'd0) ? zrun + 1 : 0;
            if ($countones(s) == 1) orun = (s == mprev) ? orun + 1 : 1;
            else orun = 0;
            mprev = s;
            if (!armed) begin
                if (zrun >= DC) armed = 1'b1;
            end else if (orun == DC) begin
                armed = 1'b0;
                model_press(s);
            end
            mkq = key;
        end
        m_bcd = pack_q();
        m_cnt = q.size();
    end

    always @(posedge clk) begin
        #2;
        check("key_strobe", key_strobe, m_strobe);
        check("key_code", key_code, m_code);
        check("entry_bcd", entry_bcd, m_bcd);
        check("digit_count", digit_count, m_cnt);
        check("entry_value", entry_value, m_val);
        check("entry_len", entry_len, m_len);
        check("entry_valid", entry_valid, m_valid);
        check("overflow", overflow, m_ovf);
        if (key_strobe) n_strobe++;
        if (entry_valid) n_valid++;
        if (overflow) n_ovf++;
    end

    task automatic tap(input logic [11:0] k);
        key = k;
        repeat (6) @(negedge clk);
        key = 12'd0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int lat, s0, v0, o0, kind, len, a, b;
        logic [11:0] v, prev_v;

        // Reset held with '1' pressed: everything stays at zero.
        key = 12'h001;
        repeat (3) @(negedge clk);
        check("rst_strobe", key_strobe, 0);
        check("rst_code", key_code, 0);
        check("rst_bcd", entry_bcd, 0);
        check("rst_count", digit_count, 0);
        check("rst_value", entry_value, 0);
        check("rst_len", entry_len, 0);
        check("rst_valid", entry_valid, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b1;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #2;
            if (key_strobe) begin
                lat = i;
                break;
            end
        end
        check("first_strobe_edge", lat, DC);
        check("first_code", key_code, 1);
        @(negedge clk);
        repeat (6) @(negedge clk);
        key = 12'd0;
        repeat (6) @(negedge clk);

        // Entry and commit.
        tap(12'h200);
        tap(12'h001); tap(12'h002); tap(12'h004); tap(12'h008);
        check("lit_bcd_1234", entry_bcd, 16'h1234);
        check("lit_count_4", digit_count, 4);
        check("model_bcd_1234", m_bcd, 16'h1234);
        v0 = n_valid;
        tap(12'h800);
        check("commit_pulses", n_valid - v0, 1);
        check("commit_value", entry_value, 16'h1234);
        check("commit_len", entry_len, 4);
        check("commit_clear_bcd", entry_bcd, 0);
        check("commit_clear_cnt", digit_count, 0);

        // Overflow then clear.
        tap(12'h001); tap(12'h002); tap(12'h004); tap(12'h008);
        o0 = n_ovf;
        tap(12'h010);
        check("ovf_pulses", n_ovf - o0, 1);
        check("ovf_bcd_kept", entry_bcd, 16'h1234);
        tap(12'h200);
        check("clr_bcd", entry_bcd, 0);
        check("clr_cnt", digit_count, 0);
        check("clr_code", key_code, 10);

        // Bounce: short bursts give nothing, a 5-cycle hold gives one press.
        s0 = n_strobe;
        repeat (4) begin
            key = 12'h010; repeat (2) @(negedge clk);
            key = 12'h000; repeat (1) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check("bounce_none", n_strobe - s0, 0);
        key = 12'h010; repeat (5) @(negedge clk);
        key = 12'h000; repeat (6) @(negedge clk);
        check("bounce_one", n_strobe - s0, 1);
        check("bounce_code", key_code, 5);

        // Ghost, long hold, key roll-over.
        s0 = n_strobe;
        key = 12'h003; repeat (20) @(negedge clk);
        key = 12'h000; repeat (6) @(negedge clk);
        check("ghost_none", n_strobe - s0, 0);
        key = 12'h040; repeat (100) @(negedge clk);
        check("hold_one", n_strobe - s0, 1);
        key = 12'h080; repeat (20) @(negedge clk);
        check("rollover_none", n_strobe - s0, 1);
        key = 12'h000; repeat (6) @(negedge clk);
        check("model_bcd_57", m_bcd, 16'h0057);

        // Empty commit.
        s0 = n_strobe;
        tap(12'h200);
        v0 = n_valid;
        tap(12'h800);
        check("empty_strobes", n_strobe - s0, 2);
        check("empty_code", key_code, 11);
        check("empty_no_valid", n_valid - v0, 0);
        check("empty_value_kept", entry_value, 16'h1234);

        // Random traffic, with one reset mid-stream.
        prev_v = 12'd0;
        for (int sg = 0; sg < 250; sg++) begin
            kind = $urandom_range(0, 5);
            v = 12'd0;
            if (kind >= 2 && kind <= 4) begin
                a = $urandom_range(0, 11);
                v[a] = 1'b1;
            end else if (kind == 5) begin
                a = $urandom_range(0, 11);
                b = (a + $urandom_range(1, 11)) % 12;
                v[a] = 1'b1;
                v[b] = 1'b1;
            end
            len = $urandom_range(1, 2 * DC + 3);
            if (v != 12'd0 && prev_v != 12'd0 && v != prev_v) begin
                key = 12'd0;
                @(negedge clk);
            end
            key = v;
            repeat (len) @(negedge clk);
            prev_v = v;
            if (sg == 120) begin
                reset = 1'b0;
                repeat (2) @(negedge clk);
                reset = 1'b1;
            end
        end
        key = 12'd0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Digit-entry stage directly downstream of the 3x4 keypad scanner. It takes the scanner's 12-bit held-key vector, re-synchronises and debounces it, and rejects ghost or multi-key patterns. It turns each accepted press into one key event, and builds a DIGITS-long BCD number with '*' to clear and '#' to commit. The committed value and a one-cycle valid pulse go to the game/display logic.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive identical samples required to accept a press or a release (min 2).
- DIGITS, 4: BCD digits held in the entry buffer.
- clk  input  1  system clock; the scanner runs on the same clock.
- reset  input  1  reset, asynchronous, active-low.
- key  input  12  scanner held-key bits:
  - bits 0-8 = digits 1-9
  - bit 9 = '*'
  - bit 10 = digit 0
  - bit 11 = '#'
- key_strobe  output  1  one-cycle pulse per accepted press.
- key_code  output  4  code of the last accepted key: 0-9 digits, 10 = '*', 11 = '#'. Held between strobes.
- entry_bcd  output  4*DIGITS  live buffer; newest digit in [3:0].
- digit_count  output  clog2(DIGITS+1)  digits currently in the buffer.
- entry_value  output  4*DIGITS  last committed buffer contents.
- entry_len  output  clog2(DIGITS+1)  digit count of the last commit.
- entry_valid  output  1  one-cycle pulse when entry_value/entry_len update.
- overflow  output  1  one-cycle pulse when a digit is rejected because the buffer is full.

## Operation
- key is registered once into key_q; all decisions use key_q.
- One-hot check: key_q is valid only when exactly one bit is set. Zero or multiple bits count as "no valid key".
- FSM states IDLE, DEB_PRESS, HELD, DEB_REL. cnt counts consecutive identical samples.
  - IDLE: key_q one-hot -> DEB_PRESS, latch cand = key_q, cnt = 1. Otherwise stay.
  - DEB_PRESS:
    - key_q != cand -> IDLE (no event).
    - key_q == cand and cnt == DEBOUNCE_CYCLES-1 -> HELD, and the press is accepted.
    - else cnt++.
  - HELD: key_q == 0 -> DEB_REL, cnt = 1. Any nonzero value, including a different key, stays in HELD with no event.
  - DEB_REL:
    - key_q != 0 -> HELD.
    - cnt == DEBOUNCE_CYCLES-1 -> IDLE.
    - else cnt++.
- Press accept actions, all registered on the same edge as key_strobe:
  - key_code <= encoded cand.
  - Digit with digit_count < DIGITS: entry_bcd <= {entry_bcd[4*DIGITS-5:0], digit}; digit_count++.
  - Digit with digit_count == DIGITS: buffer unchanged; overflow pulse.
  - '*': entry_bcd <= 0, digit_count <= 0.
  - '#' with digit_count > 0:
    - entry_value <= entry_bcd, entry_len <= digit_count, entry_valid pulse.
    - Then clear entry_bcd and digit_count.
  - '#' with digit_count == 0: no commit, no entry_valid; key_strobe still pulses.
- Leading zeros are stored as digits and count toward digit_count.

## Timing
- Reset values: all outputs 0; FSM in IDLE; key_q, cand, cnt are 0.
- key set before edge 0 and held constant:
  - key_q is valid after edge 0.
  - key_strobe, entry updates, entry_valid and overflow are visible after edge DEBOUNCE_CYCLES and last exactly one cycle.
- A glitch shorter than DEBOUNCE_CYCLES samples produces no event.
- Release then re-press of the same key needs DEBOUNCE_CYCLES zero samples, then DEBOUNCE_CYCLES stable samples. Minimum spacing between strobes is 2*DEBOUNCE_CYCLES cycles.
- key_strobe, entry_valid and overflow are never asserted for more than one cycle, and at most one event is produced per physical press.
- Reset asserted mid-debounce or mid-entry forces all state to reset values immediately. No pulse is produced on reset release.
- Counter width is clog2(DEBOUNCE_CYCLES); cnt never wraps.

## Test plan
Run with DEBOUNCE_CYCLES=4 and DIGITS=4.
- Reset: drive reset low while key=12'h001 -> all outputs 0; after release, the first strobe comes 4 cycles after key is stable.
- Entry and commit: press '1','2','3','4' (key bits 0,1,2,3), each held 6 cycles and released 6 cycles.
  - Result: entry_bcd=16'h1234, digit_count=4.
  - Then press '#': entry_value=16'h1234, entry_len=4, one entry_valid pulse; entry_bcd=0, digit_count=0.
- Overflow and clear: with 4 digits entered, press '5' -> overflow pulse, entry_bcd unchanged. Press '*' -> entry_bcd=0, digit_count=0, key_code=10.
- Bounce: toggle key bit 4 high for 2 cycles, low for 1, 4 times -> no key_strobe. Then hold it 5 cycles -> one strobe, key_code=5.
- Ghost and hold: key=12'h003 held -> no strobe. Single key held 100 cycles -> exactly one strobe. Switching to a different key while held -> no new strobe until all keys are released.
- Empty commit: press '#' with digit_count=0 -> key_strobe with key_code=11, no entry_valid, entry_value unchanged.
